// File: rtl/picorv_arb_pkg.sv
// picorv_arb_pkg: shared types, constants and the arbitration decision
// for the two-master PicoRV32 native memory port arbiter.
package picorv_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Requester identifier: 0 = CPU core, 1 = secondary master.
  typedef logic req_id_t;

  localparam req_id_t REQ_M0 = 1'b0;
  localparam req_id_t REQ_M1 = 1'b1;

  // Read data handed back to a requester whose transaction was abandoned.
  localparam logic [31:0] DEFAULT_TIMEOUT_RDATA = 32'hDEADBEEF;

  // Request attributes captured at grant and replayed downstream.
  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_attr_t;

  // Pick the winner among the requesters valid this cycle. With both valid,
  // fixed priority favours m0; otherwise the one not granted last time wins.
  function automatic req_id_t pick_winner(input logic    v0,
                                          input logic    v1,
                                          input logic    fixed_prio,
                                          input req_id_t last_grant);
    req_id_t w;
    if (v0 && v1) begin
      if (fixed_prio) begin
        w = REQ_M0;
      end else begin
        w = ~last_grant;
      end
    end else if (v0) begin
      w = REQ_M0;
    end else begin
      w = REQ_M1;
    end
    return w;
  endfunction

endpackage

// File: rtl/picorv_arb_watchdog.sv
// picorv_arb_watchdog: counts cycles spent waiting on the downstream port and
// flags expiry on the last permitted cycle. TIMEOUT_CYCLES = 0 disables it.
module picorv_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic w_unused;
      assign w_unused = ^{clk, reset, clear, enable};
      assign expired  = 1'b0;
    end else begin : g_enabled
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] r_count;

      // Cycle counter: cleared when a new transaction starts, advanced while waiting.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_count <= '0;
        end else if (clear) begin
          r_count <= '0;
        end else if (enable) begin
          r_count <= r_count + CW'(1);
        end else begin
          r_count <= r_count;
        end
      end

      // Expiry is only meaningful while a transaction is outstanding.
      assign expired = enable && (r_count == LAST_COUNT);
    end
  endgenerate

endmodule

// File: rtl/picorv_mem_arbiter.sv
// picorv_mem_arbiter: shares one PicoRV32 native memory port between the CPU
// core (m0) and a secondary master (m1). Attributes of the winning request are
// latched at grant so the downstream adapter sees stable signals; a watchdog
// forces completion of transactions the downstream side never answers.
module picorv_mem_arbiter
  import picorv_arb_pkg::*;
#(
  parameter bit          FIXED_PRIO     = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic        grant_id,
  output logic        busy,
  output logic        err_timeout
);

  arb_state_t  r_state;
  arb_state_t  w_state_next;
  req_id_t     r_last_grant;
  req_id_t     r_grant_id;
  req_id_t     w_winner;
  logic        w_grant;
  req_attr_t   r_attr;
  req_attr_t   w_m0_attr;
  req_attr_t   w_m1_attr;
  req_attr_t   w_win_attr;
  logic        w_in_busy;
  logic        w_expired;
  logic        w_finish;
  logic        w_timeout;
  logic [31:0] w_resp_data;

  assign w_m0_attr  = '{instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign w_m1_attr  = '{instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
  assign w_win_attr = (w_winner == REQ_M0) ? w_m0_attr : w_m1_attr;
  assign w_in_busy  = (r_state == BUSY);

  // Next-state logic: grant from IDLE, finish BUSY on ready or expiry, one DONE cycle.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_winner     = r_last_grant;
    case (r_state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          w_grant      = 1'b1;
          w_winner     = pick_winner(m0_valid, m1_valid, FIXED_PRIO, r_last_grant);
          w_state_next = BUSY;
        end else begin
          w_state_next = IDLE;
        end
      end
      BUSY: begin
        if (w_finish) begin
          w_state_next = DONE;
        end else begin
          w_state_next = BUSY;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Response path: route completion (real or forced) to the granted requester only.
  always_comb begin
    w_finish    = w_in_busy && (mem_ready || w_expired);
    w_timeout   = w_in_busy && w_expired && !mem_ready;
    w_resp_data = mem_ready ? mem_rdata : TIMEOUT_RDATA;
    m0_ready    = w_finish && (r_grant_id == REQ_M0);
    m1_ready    = w_finish && (r_grant_id == REQ_M1);
    if (m0_ready) begin
      m0_rdata = w_resp_data;
    end else begin
      m0_rdata = 32'h0000_0000;
    end
    if (m1_ready) begin
      m1_rdata = w_resp_data;
    end else begin
      m1_rdata = 32'h0000_0000;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant bookkeeping; last grant starts at m1 so m0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= REQ_M1;
      r_grant_id   <= REQ_M0;
    end else if (w_grant) begin
      r_last_grant <= w_winner;
      r_grant_id   <= w_winner;
    end else begin
      r_last_grant <= r_last_grant;
      r_grant_id   <= r_grant_id;
    end
  end

  // Attribute latch: downstream signals stay frozen for the whole transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_attr <= '0;
    end else if (w_grant) begin
      r_attr <= w_win_attr;
    end else begin
      r_attr <= r_attr;
    end
  end

  picorv_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_grant),
    .enable  (w_in_busy),
    .expired (w_expired)
  );

  assign mem_valid   = w_in_busy;
  assign busy        = w_in_busy;
  assign mem_instr   = r_attr.instr;
  assign mem_addr    = r_attr.addr;
  assign mem_wdata   = r_attr.wdata;
  assign mem_wstrb   = r_attr.wstrb;
  assign grant_id    = r_grant_id;
  assign err_timeout = w_timeout;

endmodule
